// File: rtl/enet_pkg.sv
// Shared types and default timing for the DM9000A host-bus arbiter.
package enet_pkg;

    localparam int DATA_W      = 16;
    localparam int T_SETUP_DEF = 1;
    localparam int T_PULSE_DEF = 3;
    localparam int T_REC_DEF   = 2;

    localparam int REQ_CFG = 0;
    localparam int REQ_TX  = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        REC   = 2'd3
    } bus_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dm9000a_bus_cycle.sv
// One DM9000A index/data bus cycle: setup, strobe pulse, recovery.
module dm9000a_bus_cycle
    import enet_pkg::*;
#(
    parameter int DW      = DATA_W,
    parameter int T_SETUP = T_SETUP_DEF,
    parameter int T_PULSE = T_PULSE_DEF,
    parameter int T_REC   = T_REC_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          cmd,
    input  logic          wr,
    input  logic [DW-1:0] wdata,
    input  logic [DW-1:0] data_i,
    output logic          idle,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic          cs_n,
    output logic          cmd_o,
    output logic          wr_n,
    output logic          rd_n,
    output logic [DW-1:0] data_o,
    output logic          data_oe
);

    localparam int TMAX = max3(T_SETUP, T_PULSE, T_REC);
    localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [CW-1:0] C_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] C_PULSE = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] C_REC   = CW'(T_REC - 1);

    bus_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cmd_q, cmd_d;
    logic          wr_q, wr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cmd_q   <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    cnt_d   = C_SETUP;
                    cmd_d   = cmd;
                    wr_d    = wr;
                    wdata_d = wdata;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = C_PULSE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = REC;
                    cnt_d   = C_REC;
                    // pad is captured on the edge that ends the strobe
                    if (!wr_q) rdata_d = data_i;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            REC: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // pins decode straight from state so a reset releases them at once
    assign idle    = (state_q == IDLE);
    assign done    = (state_q == REC) && (cnt_q == C_REC);
    assign rdata   = rdata_q;
    assign cs_n    = !((state_q == SETUP) || (state_q == PULSE));
    assign cmd_o   = idle ? 1'b0 : cmd_q;
    assign wr_n    = !((state_q == PULSE) && wr_q);
    assign rd_n    = !((state_q == PULSE) && !wr_q);
    assign data_oe = !idle && wr_q;
    assign data_o  = data_oe ? wdata_q : '0;

endmodule

// File: rtl/dm9000a_bus_arbiter.sv
// Two-port arbiter sharing the DM9000A host bus; lock keeps pairs/bursts atomic.
module dm9000a_bus_arbiter
    import enet_pkg::*;
#(
    parameter int DW      = DATA_W,
    parameter int T_SETUP = T_SETUP_DEF,
    parameter int T_PULSE = T_PULSE_DEF,
    parameter int T_REC   = T_REC_DEF
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_cmd,
    input  logic [1:0]          req_wr,
    input  logic [1:0]          req_last,
    input  logic [1:0][DW-1:0]  req_wdata,
    output logic [1:0]          req_ready,
    output logic [1:0]          rsp_valid,
    output logic [DW-1:0]       rsp_rdata,
    output logic                busy,
    output logic                ENET_CS_N,
    output logic                ENET_CMD,
    output logic                ENET_WR_N,
    output logic                ENET_RD_N,
    output logic [DW-1:0]       ENET_DATA_O,
    output logic                ENET_DATA_OE,
    input  logic [DW-1:0]       ENET_DATA_I
);

    logic lock_q, lock_d;
    logic ptr_q, ptr_d;
    logic owner_q, owner_d;
    logic grant;
    logic accept;
    logic idle;
    logic done;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lock_q  <= 1'b0;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            lock_q  <= lock_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        grant = 1'b0;
        if (lock_q)              grant = owner_q;
        else if (&req_valid)     grant = ptr_q;
        else if (req_valid[1])   grant = 1'b1;
    end

    always_comb begin
        req_ready        = '0;
        req_ready[grant] = idle && req_valid[grant];
    end

    assign accept = |req_ready;

    always_comb begin
        lock_d  = lock_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (accept) begin
            owner_d = grant;
            lock_d  = !req_last[grant];
            if (req_last[grant]) ptr_d = !ptr_q;
        end
    end

    always_comb begin
        rsp_valid          = '0;
        rsp_valid[owner_q] = done;
    end

    assign busy = !idle;

    dm9000a_bus_cycle #(
        .DW      (DW),
        .T_SETUP (T_SETUP),
        .T_PULSE (T_PULSE),
        .T_REC   (T_REC)
    ) u_cycle (
        .clk     (CLK),
        .rst_n   (RST_N),
        .start   (accept),
        .cmd     (req_cmd[grant]),
        .wr      (req_wr[grant]),
        .wdata   (req_wdata[grant]),
        .data_i  (ENET_DATA_I),
        .idle    (idle),
        .done    (done),
        .rdata   (rsp_rdata),
        .cs_n    (ENET_CS_N),
        .cmd_o   (ENET_CMD),
        .wr_n    (ENET_WR_N),
        .rd_n    (ENET_RD_N),
        .data_o  (ENET_DATA_O),
        .data_oe (ENET_DATA_OE)
    );

    a_timing: assert property (@(posedge CLK)
        (T_SETUP >= 1) && (T_PULSE >= 1) && (T_REC >= 1));

    a_strobes: assert property (@(posedge CLK) disable iff (!RST_N)
        !(!ENET_WR_N && !ENET_RD_N));

    a_cs: assert property (@(posedge CLK) disable iff (!RST_N)
        (!ENET_WR_N || !ENET_RD_N) |-> !ENET_CS_N);

    a_rsp: assert property (@(posedge CLK) disable iff (!RST_N)
        $onehot0(rsp_valid));

    for (genvar i = 0; i < 2; i++) begin : g_hold
        a_hold: assert property (@(posedge CLK) disable iff (!RST_N)
            req_valid[i] && !req_ready[i] |=> !req_valid[i] ||
            ($stable(req_cmd[i]) && $stable(req_wr[i]) &&
             $stable(req_last[i]) && $stable(req_wdata[i])));
    end

endmodule
